// File: rtl/engine_scheduler.sv
// Round-robin pixel scheduler: grants the next raster pixel to an idle engine; grant registered 1 cycle after req.
// stall=1 suppresses grants; pointer, pixel counters and x_o/y_o hold until stall falls.
module engine_scheduler #(
    parameter int NUM_ENGINES      = 30,
    parameter int ENG_IDX_WIDTH    = 5,
    parameter int PIXEL_DATA_WIDTH = 10,
    parameter int SCREEN_WIDTH     = 640,
    parameter int SCREEN_HEIGHT    = 480
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [2:0]                  zoom_i,
    input  logic [24:0]                 x_offset_i,
    input  logic [24:0]                 y_offset_i,
    input  logic [NUM_ENGINES-1:0]      req,
    input  logic                        stall,
    output logic [NUM_ENGINES-1:0]      grant,
    output logic [ENG_IDX_WIDTH-1:0]    grant_idx,
    output logic [PIXEL_DATA_WIDTH-1:0] x_o,
    output logic [PIXEL_DATA_WIDTH-1:0] y_o,
    output logic [2:0]                  zoom_o,
    output logic [24:0]                 x_offset_o,
    output logic [24:0]                 y_offset_o,
    output logic                        busy,
    output logic                        frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DRAIN
    } state_t;

    localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST   = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST   = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);
    localparam logic [ENG_IDX_WIDTH-1:0]    IDX_LAST = ENG_IDX_WIDTH'(NUM_ENGINES - 1);
    localparam logic [NUM_ENGINES-1:0]      ONE_HOT0 = NUM_ENGINES'(1);

    state_t                        state_q;
    state_t                        state_d;
    logic [ENG_IDX_WIDTH-1:0]      ptr_q;
    logic [PIXEL_DATA_WIDTH-1:0]   x_cnt_q;
    logic [PIXEL_DATA_WIDTH-1:0]   y_cnt_q;
    logic [NUM_ENGINES-1:0]        eligible;
    logic [ENG_IDX_WIDTH-1:0]      pick_idx;
    logic [ENG_IDX_WIDTH-1:0]      cand_idx;
    int                            cand;
    logic                          pick_vld;
    logic                          last_pixel;
    logic                          do_start;
    logic                          do_grant;
    logic                          do_done;

    // An engine whose grant is on the wire is masked so a late-falling req cannot win twice.
    assign eligible   = req & ~grant;
    assign last_pixel = (x_cnt_q == X_LAST) && (y_cnt_q == Y_LAST);

    // Descending scan so the candidate closest above the pointer is written last and wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_ENGINES) begin
                cand = cand - NUM_ENGINES;
            end
            cand_idx = ENG_IDX_WIDTH'(cand);
            if (eligible[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        do_start = 1'b0;
        do_grant = 1'b0;
        do_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    do_start = 1'b1;
                    state_d  = DISPATCH;
                end
            end
            DISPATCH: begin
                if (!stall && pick_vld) begin
                    do_grant = 1'b1;
                    if (last_pixel) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((&req) && (grant == '0)) begin
                    do_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy       <= (state_d != IDLE);
            frame_done <= do_done;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zoom_o     <= '0;
            x_offset_o <= '0;
            y_offset_o <= '0;
        end else if (do_start) begin
            zoom_o     <= zoom_i;
            x_offset_o <= x_offset_i;
            y_offset_o <= y_offset_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant     <= '0;
            grant_idx <= '0;
            x_o       <= '0;
            y_o       <= '0;
            ptr_q     <= '0;
        end else begin
            grant <= '0;
            if (do_grant) begin
                grant     <= ONE_HOT0 << pick_idx;
                grant_idx <= pick_idx;
                x_o       <= x_cnt_q;
                y_o       <= y_cnt_q;
                ptr_q     <= (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
            end
        end
    end

    // Raster counters point at the next unissued pixel; the final pixel rewinds them for the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
        end else if (do_start) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
        end else if (do_grant) begin
            if (x_cnt_q == X_LAST) begin
                x_cnt_q <= '0;
                y_cnt_q <= last_pixel ? '0 : y_cnt_q + 1'b1;
            end else begin
                x_cnt_q <= x_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_engine_scheduler.sv
// Bench for engine_scheduler: directed vector table, directed multi-cycle sequences, and a random run against a pixel-index model.
module tb_engine_scheduler;

    localparam int NE = 4;
    localparam int SW = 4;
    localparam int SH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  zoom_i;
    logic [24:0] x_offset_i;
    logic [24:0] y_offset_i;
    logic [3:0]  req;
    logic        stall;
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic [9:0]  x_o;
    logic [9:0]  y_o;
    logic [2:0]  zoom_o;
    logic [24:0] x_offset_o;
    logic [24:0] y_offset_o;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    engine_scheduler #(
        .NUM_ENGINES(NE), .ENG_IDX_WIDTH(2), .PIXEL_DATA_WIDTH(10),
        .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .zoom_i(zoom_i),
        .x_offset_i(x_offset_i), .y_offset_i(y_offset_i), .req(req), .stall(stall),
        .grant(grant), .grant_idx(grant_idx), .x_o(x_o), .y_o(y_o), .zoom_o(zoom_o),
        .x_offset_o(x_offset_o), .y_offset_o(y_offset_o), .busy(busy), .frame_done(frame_done)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frame progress is a single pixel index, x/y derived by division.
    int          m_phase;  // 0 idle, 1 dispatching, 2 draining
    int          m_ptr, m_n, m_idx, m_x, m_y;
    logic [3:0]  m_grant;
    bit          m_busy, m_done;
    logic [2:0]  m_zoom;
    logic [24:0] m_xo, m_yo;

    task automatic model_edge();
        logic [3:0] prev;
        logic [3:0] elig;
        int         k;
        int         j;
        bit         found;
        if (!reset) begin
            m_phase = 0; m_ptr = 0; m_n = 0; m_grant = '0; m_idx = 0; m_x = 0; m_y = 0;
            m_busy = 0; m_done = 0; m_zoom = '0; m_xo = '0; m_yo = '0;
            return;
        end
        prev    = m_grant;
        m_grant = '0;
        m_done  = 0;
        case (m_phase)
            0: begin
                if (start) begin
                    m_zoom = zoom_i; m_xo = x_offset_i; m_yo = y_offset_i;
                    m_n = 0; m_phase = 1;
                end
            end
            1: begin
                elig  = req & ~prev;
                found = 0;
                k     = 0;
                if (!stall) begin
                    for (int s = 0; s < NE; s++) begin
                        j = (m_ptr + s) % NE;
                        if (!found && elig[2'(j)]) begin
                            found = 1;
                            k = j;
                        end
                    end
                end
                if (found) begin
                    m_grant = 4'b0001 << k;
                    m_idx   = k;
                    m_x     = m_n % SW;
                    m_y     = m_n / SW;
                    m_ptr   = (k + 1) % NE;
                    m_n++;
                    if (m_n == SW * SH) begin
                        m_n = 0;
                        m_phase = 2;
                    end
                end
            end
            default: begin
                if (req == 4'hF && prev == 4'h0) begin
                    m_done = 1;
                    m_phase = 0;
                end
            end
        endcase
        m_busy = (m_phase != 0);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_grant"}, grant, m_grant);
        chk({tag, "_busy"}, busy, m_busy);
        chk({tag, "_frame_done"}, frame_done, m_done);
        chk({tag, "_zoom_o"}, zoom_o, m_zoom);
        chk({tag, "_x_offset_o"}, x_offset_o, m_xo);
        chk({tag, "_y_offset_o"}, y_offset_o, m_yo);
        if (m_grant != 4'h0) begin
            chk({tag, "_grant_idx"}, grant_idx, m_idx);
            chk({tag, "_x_o"}, x_o, m_x);
            chk({tag, "_y_o"}, y_o, m_y);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Engine behaviour: req stays up through the grant cycle (or drops at once), low while working, then back up.
    int         eng_cnt[NE];
    logic [3:0] g_seen;
    int         log_idx[$];
    int         log_x[$];
    int         log_y[$];
    int         done_cnt;
    bit         stall_force;
    int         rst_hold;

    task automatic engines_clear();
        for (int k = 0; k < NE; k++) eng_cnt[k] = 0;
        g_seen = '0;
    endtask

    task automatic run(input int cycles, input int wmin, input int wmax, input int stall_pct,
                       input bit rand_mode, input bit rand_reset);
        logic [3:0] req_n;
        for (int c = 0; c < cycles; c++) begin
            if (rand_reset) begin
                if (rst_hold > 0) begin
                    rst_hold--;
                    if (rst_hold == 0) reset = 1'b1;
                end else if ($urandom_range(0, 299) == 0) begin
                    reset = 1'b0;
                    rst_hold = $urandom_range(1, 3);
                    engines_clear();
                end
            end
            for (int k = 0; k < NE; k++) begin
                if (g_seen[k]) begin
                    eng_cnt[k] = $urandom_range(wmin, wmax);
                    req_n[k] = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                end else if (eng_cnt[k] > 0) begin
                    eng_cnt[k]--;
                    req_n[k] = 1'b0;
                end else begin
                    req_n[k] = 1'b1;
                end
            end
            req   = req_n;
            stall = stall_force || ($urandom_range(0, 99) < stall_pct);
            if (rand_mode) begin
                start      = ($urandom_range(0, 3) == 0);
                zoom_i     = 3'($urandom);
                x_offset_i = 25'($urandom);
                y_offset_i = 25'($urandom);
            end
            model_edge();
            step();
            check_all(rand_mode ? "rand" : "seq");
            g_seen = grant;
            if (grant != 4'h0) begin
                log_idx.push_back(int'(grant_idx));
                log_x.push_back(int'(x_o));
                log_y.push_back(int'(y_o));
            end
            if (frame_done) done_cnt++;
            if (!rand_mode) start = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        req   = 4'hF;
        model_edge();
        step();
        check_all("rst");
        engines_clear();
        reset = 1'b1;
    endtask

    task automatic log_clear();
        log_idx.delete();
        log_x.delete();
        log_y.delete();
    endtask

    typedef struct {
        bit         start;
        logic [3:0] req;
        bit         stall;
        logic [3:0] g;
        logic [1:0] idx;
        int         x;
        int         y;
        bit         busy;
        bit         done;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; stall = 1'b0; req = 4'hF;
        zoom_i = '0; x_offset_i = '0; y_offset_i = '0;
        stall_force = 0; rst_hold = 0; done_cnt = 0;
        engines_clear();

        // Outputs while reset is held.
        step(); step();
        chk("rst_grant", grant, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_x_o", x_o, 0);
        chk("rst_y_o", y_o, 0);
        chk("rst_zoom_o", zoom_o, 0);
        chk("rst_x_offset_o", x_offset_o, 0);
        chk("rst_y_offset_o", y_offset_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);

        // Released with all engines requesting but no start: nothing may move.
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_grant", grant, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", frame_done, 0);
            chk("idle_xy", {x_o, y_o}, 0);
            chk("idle_zoom", zoom_o, 0);
        end

        // Hand-derived per-cycle vectors: start, round-robin, stall, sparse req, drain, start-with-done.
        tbl[0]  = '{1'b1, 4'hF, 1'b0, 4'h0, 2'd0, 0, 0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 4'hF, 1'b0, 4'h1, 2'd0, 0, 0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'hF, 1'b0, 4'h2, 2'd1, 1, 0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'hE, 1'b0, 4'h4, 2'd2, 2, 0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'hC, 1'b1, 4'h0, 2'd0, 0, 0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'h8, 1'b1, 4'h0, 2'd0, 0, 0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'h8, 1'b0, 4'h8, 2'd3, 3, 0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 0, 0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'h4, 1'b0, 4'h4, 2'd2, 0, 1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 4'h4, 1'b0, 4'h0, 2'd0, 0, 0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'h4, 1'b0, 4'h4, 2'd2, 1, 1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'h1, 1'b0, 4'h1, 2'd0, 2, 1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'h3, 1'b0, 4'h2, 2'd1, 3, 1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 4'hF, 1'b0, 4'h0, 2'd0, 0, 0, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 4'hF, 1'b0, 4'h0, 2'd0, 0, 0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 4'hF, 1'b0, 4'h0, 2'd0, 0, 0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 4'hF, 1'b0, 4'h0, 2'd0, 0, 0, 1'b1, 1'b0};
        zoom_i = 3'd3; x_offset_i = 25'h100; y_offset_i = 25'h055;
        for (int i = 0; i < 17; i++) begin
            start = tbl[i].start;
            req   = tbl[i].req;
            stall = tbl[i].stall;
            step();
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), frame_done, tbl[i].done);
            if (tbl[i].g != 4'h0) begin
                chk($sformatf("tbl%0d_idx", i), grant_idx, tbl[i].idx);
                chk($sformatf("tbl%0d_x", i), x_o, tbl[i].x);
                chk($sformatf("tbl%0d_y", i), y_o, tbl[i].y);
            end
        end
        start = 1'b0;
        chk("tbl_zoom_o", zoom_o, 3);
        chk("tbl_x_offset_o", x_offset_o, 25'h100);
        chk("tbl_y_offset_o", y_offset_o, 25'h055);

        // Full frame, engines busy for 3 cycles after each grant.
        do_reset();
        zoom_i = 3'd3; x_offset_i = 25'h100; y_offset_i = 25'h0;
        log_clear(); done_cnt = 0;
        start = 1'b1;
        run(30, 3, 3, 0, 1'b0, 1'b0);
        chk("rr_grant_count", log_idx.size(), 8);
        chk("rr_done_count", done_cnt, 1);
        for (int i = 0; i < 8 && i < log_idx.size(); i++) begin
            chk($sformatf("rr%0d_idx", i), log_idx[i], i % 4);
            chk($sformatf("rr%0d_x", i), log_x[i], i % 4);
            chk($sformatf("rr%0d_y", i), log_y[i], i / 4);
        end

        // Five stalled cycles mid-frame: no grants, no skipped or repeated pixel.
        do_reset();
        log_clear(); done_cnt = 0;
        start = 1'b1;
        run(4, 2, 2, 0, 1'b0, 1'b0);
        chk("stall_pre_grants", log_idx.size(), 3);
        stall_force = 1;
        run(5, 2, 2, 0, 1'b0, 1'b0);
        stall_force = 0;
        chk("stall_no_grants", log_idx.size(), 3);
        run(30, 2, 2, 0, 1'b0, 1'b0);
        chk("stall_grant_count", log_idx.size(), 8);
        chk("stall_done_count", done_cnt, 1);
        for (int i = 0; i < log_x.size(); i++) begin
            chk($sformatf("stall%0d_pixel", i), log_y[i] * SW + log_x[i], i);
        end

        // Reset after three grants: aborted frame never completes, new frame restarts at engine 0 / (0,0).
        do_reset();
        log_clear(); done_cnt = 0;
        start = 1'b1;
        for (int c = 0; c < 50 && log_idx.size() < 3; c++) begin
            run(1, 2, 2, 0, 1'b0, 1'b0);
        end
        chk("abort_grants_before_reset", log_idx.size(), 3);
        reset = 1'b0;
        #1;
        chk("abort_async_grant", grant, 0);
        chk("abort_async_busy", busy, 0);
        chk("abort_async_xy", {x_o, y_o}, 0);
        chk("abort_async_zoom", zoom_o, 0);
        model_edge();
        step();
        check_all("abort_rst");
        engines_clear();
        reset = 1'b1;
        req = 4'hF;
        step();
        chk("abort_no_done", done_cnt + int'(frame_done), 0);
        log_clear();
        start = 1'b1;
        model_edge();
        step();
        check_all("abort_start");
        start = 1'b0;
        run(30, 2, 2, 0, 1'b0, 1'b0);
        chk("abort_new_count", log_idx.size(), 8);
        if (log_idx.size() > 0) begin
            chk("abort_first_idx", log_idx[0], 0);
            chk("abort_first_xy", log_x[0] + log_y[0], 0);
        end
        chk("abort_done_count", done_cnt, 1);

        // Random traffic, stalls, starts and occasional resets.
        do_reset();
        done_cnt = 0;
        run(3000, 1, 6, 25, 1'b1, 1'b1);
        chk("rand_frames_completed", done_cnt > 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
